// File: rtl/rr_queue_arbiter_pkg.sv
// Shared definitions for the round-robin queue arbiter.
//   id_width()      : tag / pointer width helper, never narrower than 1 bit
//   burst_state_e   : burst FSM encoding (IDLE = unlocked, BURST = locked)
//   q_entry_t       : queue entry layout {chosen, bits} at the default widths
package rr_queue_arbiter_pkg;

   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } burst_state_e;

   localparam int DEF_N_REQ  = 4;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_ID_W   = id_width(DEF_N_REQ);

   // The queue sub-module declares the same layout with its own parameter widths.
   typedef struct packed {
      logic [DEF_ID_W-1:0]   chosen;
      logic [DEF_DATA_W-1:0] bits;
   } q_entry_t;

endpackage

// File: rtl/rr_queue_arbiter_tagged_queue.sv
// ENTRIES-deep decoupled queue of {chosen, bits} entries.
//   clk, reset        : clock, asynchronous active-high reset
//   enq_valid_i/ready_o, enq_chosen_i, enq_bits_i : write side
//   deq_valid_o/ready_i, deq_chosen_o, deq_bits_o : read side (head)
// No flow-through and no pipe mode: a full queue refuses enq even when the
// head is being dequeued in the same cycle, which keeps enq_ready_o a pure
// function of registered state.
module rr_queue_arbiter_tagged_queue
   import rr_queue_arbiter_pkg::*;
#(
   parameter int ID_W    = 2,
   parameter int DATA_W  = 8,
   parameter int ENTRIES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enq_valid_i,
   output logic              enq_ready_o,
   input  logic [ID_W-1:0]   enq_chosen_i,
   input  logic [DATA_W-1:0] enq_bits_i,
   output logic              deq_valid_o,
   input  logic              deq_ready_i,
   output logic [ID_W-1:0]   deq_chosen_o,
   output logic [DATA_W-1:0] deq_bits_o
);

   localparam int PTR_W = id_width(ENTRIES);

   typedef struct packed {
      logic [ID_W-1:0]   chosen;
      logic [DATA_W-1:0] bits;
   } entry_t;

   entry_t           mem_q [ENTRIES];
   logic [PTR_W-1:0] enq_ptr_q;
   logic [PTR_W-1:0] deq_ptr_q;
   logic             maybe_full_q;

   logic ptr_match, empty, full, do_enq, do_deq;

   assign ptr_match    = (enq_ptr_q == deq_ptr_q);
   assign empty        = ptr_match & ~maybe_full_q;
   assign full         = ptr_match &  maybe_full_q;
   assign enq_ready_o  = ~full;
   assign deq_valid_o  = ~empty;
   assign do_enq       = enq_valid_i & ~full;
   assign do_deq       = deq_ready_i & ~empty;
   assign deq_chosen_o = mem_q[deq_ptr_q].chosen;
   assign deq_bits_o   = mem_q[deq_ptr_q].bits;

   // Storage carries no reset; occupancy is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (do_enq) begin
         mem_q[enq_ptr_q] <= '{chosen: enq_chosen_i, bits: enq_bits_i};
      end
   end

   // ENTRIES is a power of two, so the pointers wrap on plain overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         enq_ptr_q    <= '0;
         deq_ptr_q    <= '0;
         maybe_full_q <= 1'b0;
      end else begin
         if (do_enq) enq_ptr_q <= enq_ptr_q + PTR_W'(1);
         if (do_deq) deq_ptr_q <= deq_ptr_q + PTR_W'(1);
         if (do_enq != do_deq) maybe_full_q <= do_enq;
      end
   end

endmodule

// File: rtl/rr_queue_arbiter.sv
// Round-robin arbiter feeding one shared tagged queue.
//   clk, reset                 : clock, asynchronous active-high reset
//   io_in_valid/ready/bits     : N_REQ decoupled requesters, payload i at [i*DATA_W +: DATA_W]
//   io_out_valid/ready         : queue head handshake
//   io_out_bits/chosen         : queue head payload and source index
//
// Burst FSM
//   state    | meaning
//   ST_IDLE  | unlocked; grant is the first valid requester from rr_ptr upward
//   ST_BURST | locked to lock_id until BEATS transfers have completed
module rr_queue_arbiter
   import rr_queue_arbiter_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int DATA_W  = 8,
   parameter int ENTRIES = 2,
   parameter int BEATS   = 1,
   localparam int ID_W   = id_width(N_REQ)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        io_in_valid,
   output logic [N_REQ-1:0]        io_in_ready,
   input  logic [N_REQ*DATA_W-1:0] io_in_bits,
   output logic                    io_out_valid,
   input  logic                    io_out_ready,
   output logic [DATA_W-1:0]       io_out_bits,
   output logic [ID_W-1:0]         io_out_chosen
);

   localparam int              CNT_W     = id_width(BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   burst_state_e      state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   lock_id_q, lock_id_d;
   logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

   logic [ID_W-1:0]   grant;
   logic              grant_exists;
   logic [DATA_W-1:0] grant_bits;
   logic              enq_valid, enq_ready, fire;

   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= N_REQ) s = s - N_REQ;
      return ID_W'(s);
   endfunction

   // Scan offsets from highest to lowest so the nearest valid requester
   // (smallest offset from rr_ptr) is the last assignment and wins.
   always_comb begin
      grant        = rr_ptr_q;
      grant_exists = 1'b0;
      if (state_q == ST_BURST) begin
         grant        = lock_id_q;
         grant_exists = 1'b1;
      end else begin
         for (int k = N_REQ - 1; k >= 0; k--) begin
            if (io_in_valid[wrap_add(rr_ptr_q, k)]) begin
               grant        = wrap_add(rr_ptr_q, k);
               grant_exists = 1'b1;
            end
         end
      end
   end

   assign grant_bits = io_in_bits[int'(grant)*DATA_W +: DATA_W];
   assign enq_valid  = grant_exists & io_in_valid[grant];
   assign fire       = enq_valid & enq_ready;

   // enq_ready depends only on queue registers, so io_out_ready never
   // reaches io_in_ready combinationally.
   always_comb begin
      io_in_ready = '0;
      if (grant_exists & enq_ready) io_in_ready[grant] = 1'b1;
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      lock_id_d  = lock_id_q;
      beat_cnt_d = beat_cnt_q;
      if (fire) begin
         unique case (state_q)
            ST_IDLE: begin
               if (BEATS == 1) begin
                  rr_ptr_d = wrap_add(grant, 1);
               end else begin
                  state_d    = ST_BURST;
                  lock_id_d  = grant;
                  beat_cnt_d = CNT_W'(1);
               end
            end
            ST_BURST: begin
               if (beat_cnt_q == LAST_BEAT) begin
                  state_d    = ST_IDLE;
                  beat_cnt_d = '0;
                  rr_ptr_d   = wrap_add(lock_id_q, 1);
               end else begin
                  beat_cnt_d = beat_cnt_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         lock_id_q  <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         lock_id_q  <= lock_id_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   rr_queue_arbiter_tagged_queue #(
      .ID_W    (ID_W),
      .DATA_W  (DATA_W),
      .ENTRIES (ENTRIES)
   ) u_queue (
      .clk          (clk),
      .reset        (reset),
      .enq_valid_i  (enq_valid),
      .enq_ready_o  (enq_ready),
      .enq_chosen_i (grant),
      .enq_bits_i   (grant_bits),
      .deq_valid_o  (io_out_valid),
      .deq_ready_i  (io_out_ready),
      .deq_chosen_o (io_out_chosen),
      .deq_bits_o   (io_out_bits)
   );

endmodule

// File: tb/tb_rr_queue_arbiter.sv
// Bench for rr_queue_arbiter: one instance with BEATS=1 (suffix _a) and one
// with BEATS=3 (suffix _b), both N_REQ=4, DATA_W=8, ENTRIES=2.
module tb_rr_queue_arbiter;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [3:0]  vld_a, vld_b, rdy_a, rdy_b;
   logic [31:0] bits_a, bits_b;
   logic        ordy_a, ordy_b, ovld_a, ovld_b;
   logic [7:0]  obits_a, obits_b;
   logic [1:0]  ochs_a, ochs_b;

   rr_queue_arbiter #(.N_REQ(4), .DATA_W(8), .ENTRIES(2), .BEATS(1)) u_dut_a (
      .clk(clk), .reset(reset),
      .io_in_valid(vld_a), .io_in_ready(rdy_a), .io_in_bits(bits_a),
      .io_out_valid(ovld_a), .io_out_ready(ordy_a),
      .io_out_bits(obits_a), .io_out_chosen(ochs_a));

   rr_queue_arbiter #(.N_REQ(4), .DATA_W(8), .ENTRIES(2), .BEATS(3)) u_dut_b (
      .clk(clk), .reset(reset),
      .io_in_valid(vld_b), .io_in_ready(rdy_b), .io_in_bits(bits_b),
      .io_out_valid(ovld_b), .io_out_ready(ordy_b),
      .io_out_bits(obits_b), .io_out_chosen(ochs_b));

   int total;
   int bad;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: owner/beats-remaining view of the arbiter and an
   // in-order list (index 0 = head) for the queue.
   int         m_rr[2], m_owner[2], m_left[2], m_cnt[2];
   logic [9:0] m_q[2][4];

   function automatic void m_reset(input int m);
      m_rr[m] = 0; m_owner[m] = -1; m_left[m] = 0; m_cnt[m] = 0;
   endfunction

   function automatic int m_grant(input int m, input logic [3:0] v);
      if (m_owner[m] >= 0) return m_owner[m];
      for (int k = 0; k < 4; k++)
         if (v[(m_rr[m] + k) % 4]) return (m_rr[m] + k) % 4;
      return -1;
   endfunction

   function automatic logic [3:0] m_ready(input int m, input logic [3:0] v);
      int g;
      g = m_grant(m, v);
      if (g >= 0 && m_cnt[m] < 2) return 4'(1 << g);
      return 4'b0000;
   endfunction

   function automatic void m_step(input int m, input logic [3:0] v, input logic [31:0] b,
                                  input logic ordy);
      int g, beats;
      bit fire, deq;
      beats = (m == 0) ? 1 : 3;
      g     = m_grant(m, v);
      fire  = (g >= 0) && (m_cnt[m] < 2) && v[g];
      deq   = (m_cnt[m] > 0) && ordy;
      if (deq) begin
         for (int i = 0; i < 3; i++) m_q[m][i] = m_q[m][i+1];
         m_cnt[m]--;
      end
      if (fire) begin
         m_q[m][m_cnt[m]] = {2'(g), b[g*8 +: 8]};
         m_cnt[m]++;
         if (m_owner[m] < 0) begin
            if (beats == 1) m_rr[m] = (g + 1) % 4;
            else begin
               m_owner[m] = g;
               m_left[m]  = beats - 1;
            end
         end else begin
            m_left[m]--;
            if (m_left[m] == 0) begin
               m_owner[m] = -1;
               m_rr[m]    = (g + 1) % 4;
            end
         end
      end
   endfunction

   task automatic check_model(input int m);
      logic [3:0] v, rdy;
      logic       ov;
      logic [9:0] head;
      if (m == 0) begin
         v = vld_a; rdy = rdy_a; ov = ovld_a; head = {ochs_a, obits_a};
      end else begin
         v = vld_b; rdy = rdy_b; ov = ovld_b; head = {ochs_b, obits_b};
      end
      check($sformatf("model_ready%0d", m), rdy, m_ready(m, v));
      check($sformatf("model_ovalid%0d", m), ov, (m_cnt[m] > 0) ? 1 : 0);
      if (m_cnt[m] > 0) check($sformatf("model_head%0d", m), head, m_q[m][0]);
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic edge_();
      @(posedge clk);
      m_step(0, vld_a, bits_a, ordy_a);
      m_step(1, vld_b, bits_b, ordy_b);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      vld_a = '0; vld_b = '0; ordy_a = 1'b0; ordy_b = 1'b0; bits_a = '0; bits_b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      m_reset(0); m_reset(1);
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [3:0] vld;
      logic       ordy;
      logic [3:0] exp_rdy;
      logic       exp_ovld;
      logic [1:0] exp_chs;
      logic [7:0] exp_bits;
   } vec_t;

   typedef struct {
      logic [3:0] vld;
      logic       ordy;
      logic [3:0] exp_rdy;
      logic       exp_ovld;
   } seq_t;

   seq_t       sq[$];
   logic [1:0] obs[$];

   task automatic run_seq(input int m, input string tag);
      for (int i = 0; i < sq.size(); i++) begin
         if (m == 0) begin vld_a = sq[i].vld; ordy_a = sq[i].ordy; end
         else        begin vld_b = sq[i].vld; ordy_b = sq[i].ordy; end
         sample();
         check($sformatf("%s_ready[%0d]", tag, i), (m == 0) ? rdy_a : rdy_b, sq[i].exp_rdy);
         check($sformatf("%s_ovalid[%0d]", tag, i), (m == 0) ? ovld_a : ovld_b, sq[i].exp_ovld);
         check_model(m);
         if (m == 1 && ovld_b && ordy_b) obs.push_back(ochs_b);
         edge_();
      end
   endtask

   initial begin
      vec_t tbl[6];
      int   exp_ord[6];
      total = 0;
      bad   = 0;
      exp_ord = '{0, 0, 0, 2, 2, 2};

      // Idle after reset
      do_reset();
      for (int i = 0; i < 10; i++) begin
         sample();
         check("idle_ready_a", rdy_a, 0);
         check("idle_ovalid_a", ovld_a, 0);
         check("idle_ready_b", rdy_b, 0);
         check("idle_ovalid_b", ovld_b, 0);
         edge_();
      end

      // Fairness, BEATS=1, all valid, consumer always ready
      tbl[0] = '{4'hF, 1'b1, 4'b0001, 1'b0, 2'd0, 8'h00};
      tbl[1] = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd0, 8'h10};
      tbl[2] = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd1, 8'h11};
      tbl[3] = '{4'hF, 1'b1, 4'b1000, 1'b1, 2'd2, 8'h12};
      tbl[4] = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd3, 8'h13};
      tbl[5] = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd0, 8'h10};
      bits_a = 32'h1312_1110;
      for (int i = 0; i < 6; i++) begin
         vld_a  = tbl[i].vld;
         ordy_a = tbl[i].ordy;
         sample();
         check($sformatf("rr_ready[%0d]", i), rdy_a, tbl[i].exp_rdy);
         check($sformatf("rr_ovalid[%0d]", i), ovld_a, tbl[i].exp_ovld);
         if (tbl[i].exp_ovld)
            check($sformatf("rr_head[%0d]", i), {ochs_a, obits_a}, {tbl[i].exp_chs, tbl[i].exp_bits});
         edge_();
      end

      // BEATS=3 lock holds while the owner's valid drops
      do_reset();
      bits_b = 32'h00A2_00A0;
      sq.delete();
      obs.delete();
      sq.push_back('{4'b0101, 1'b1, 4'b0001, 1'b0});
      sq.push_back('{4'b0100, 1'b1, 4'b0001, 1'b1});
      sq.push_back('{4'b0100, 1'b1, 4'b0001, 1'b0});
      sq.push_back('{4'b0101, 1'b1, 4'b0001, 1'b0});
      sq.push_back('{4'b0101, 1'b1, 4'b0001, 1'b1});
      sq.push_back('{4'b0101, 1'b1, 4'b0100, 1'b1});
      sq.push_back('{4'b0101, 1'b1, 4'b0100, 1'b1});
      sq.push_back('{4'b0101, 1'b1, 4'b0100, 1'b1});
      sq.push_back('{4'b0101, 1'b1, 4'b0001, 1'b1});
      run_seq(1, "burst");
      check("burst_order_len", obs.size(), 6);
      for (int i = 0; i < 6 && i < obs.size(); i++)
         check($sformatf("burst_order[%0d]", i), obs[i], exp_ord[i]);

      // Full queue, then a single dequeue frees exactly one slot
      do_reset();
      bits_a = 32'h0000_5500;
      sq.delete();
      sq.push_back('{4'b0010, 1'b0, 4'b0010, 1'b0});
      sq.push_back('{4'b0010, 1'b0, 4'b0010, 1'b1});
      sq.push_back('{4'b0010, 1'b0, 4'b0000, 1'b1});
      sq.push_back('{4'b0010, 1'b0, 4'b0000, 1'b1});
      sq.push_back('{4'b0010, 1'b1, 4'b0000, 1'b1});
      sq.push_back('{4'b0010, 1'b0, 4'b0010, 1'b1});
      sq.push_back('{4'b0010, 1'b0, 4'b0000, 1'b1});
      sq.push_back('{4'b0000, 1'b1, 4'b0000, 1'b1});
      sq.push_back('{4'b0000, 1'b1, 4'b0000, 1'b1});
      sq.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0});
      run_seq(0, "full");

      // Minimum latency: beat from req3 visible only after its edge
      bits_a = 32'h7700_0000;
      vld_a  = 4'b1000;
      ordy_a = 1'b1;
      sample();
      check("lat_ready_pre", rdy_a, 4'b1000);
      check("lat_ovalid_pre", ovld_a, 0);
      edge_();
      vld_a = 4'b0000;
      sample();
      check("lat_ovalid_post", ovld_a, 1);
      check("lat_head_post", {ochs_a, obits_a}, {2'd3, 8'h77});
      edge_();
      sample();
      check("lat_ovalid_drain", ovld_a, 0);
      edge_();

      // Asynchronous reset mid-burst with two queued beats
      do_reset();
      bits_b = 32'h0000_3C00;
      sq.delete();
      sq.push_back('{4'b0010, 1'b0, 4'b0010, 1'b0});
      sq.push_back('{4'b0010, 1'b0, 4'b0010, 1'b1});
      run_seq(1, "arst");
      sample();
      check("arst_full_ready", rdy_b, 4'b0000);
      check("arst_ovalid_before", ovld_b, 1);
      #2;
      reset = 1'b1;
      #1;
      check("arst_ovalid_async", ovld_b, 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      m_reset(0); m_reset(1);
      vld_a  = '0;
      vld_b  = 4'hF;
      ordy_b = 1'b1;
      bits_b = 32'h4433_2211;
      #1;
      check("arst_first_grant", rdy_b, 4'b0001);
      check_model(1);
      edge_();
      sample();
      check("arst_first_head", {ochs_b, obits_b}, {2'd0, 8'h11});
      edge_();

      // Randomised traffic against the model on both instances
      do_reset();
      for (int i = 0; i < 400; i++) begin
         vld_a  = 4'($urandom);
         vld_b  = 4'($urandom);
         ordy_a = ($urandom_range(0, 3) != 0);
         ordy_b = ($urandom_range(0, 3) != 0);
         bits_a = $urandom;
         bits_b = $urandom;
         sample();
         check_model(0);
         check_model(1);
         edge_();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
